// File: rtl/sdram_rd_arbiter.sv
// Three-requester round-robin arbiter for a shared SDRAM read port.
// Grants are burst-locked and always separated by one idle turnaround cycle.
`ifndef RAM_ADR_W
`define RAM_ADR_W 24
`endif

module sdram_rd_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  REQ0_RE_N,
    input  logic [`RAM_ADR_W-1:0] REQ0_ADDR,
    output logic                  REQ0_WAIT,
    input  logic                  REQ1_RE_N,
    input  logic [`RAM_ADR_W-1:0] REQ1_ADDR,
    output logic                  REQ1_WAIT,
    input  logic                  REQ2_RE_N,
    input  logic [`RAM_ADR_W-1:0] REQ2_ADDR,
    output logic                  REQ2_WAIT,
    output logic                  SDRAM_RE_N,
    output logic [`RAM_ADR_W-1:0] SDRAM_ADDR,
    input  logic                  SDRAM_WAIT,
    output logic [2:0]            grant,
    output logic [CNT_W-1:0]      beat_cnt
);

    localparam int unsigned ADR_W = `RAM_ADR_W;
    localparam int unsigned NREQ  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [NREQ-1:0]   grant_next;
    logic [1:0]        last;
    logic [1:0]        last_next;
    logic [CNT_W-1:0]  beat_next;

    logic [3:0]        req;
    logic [1:0]        gidx;
    logic              g_re_n;
    logic [ADR_W-1:0]  g_addr;
    logic [1:0]        cand1;
    logic [1:0]        cand2;
    logic [1:0]        pick;
    logic              pick_vld;
    logic              owned;

    // Padded to four bits so any 2-bit index stays in range.
    assign req = {1'b0, ~REQ2_RE_N, ~REQ1_RE_N, ~REQ0_RE_N};

    // Owner index and its request/address lines.
    always_comb begin
        gidx   = 2'd0;
        g_re_n = REQ0_RE_N;
        g_addr = REQ0_ADDR;
        case (grant)
            3'b010: begin
                gidx   = 2'd1;
                g_re_n = REQ1_RE_N;
                g_addr = REQ1_ADDR;
            end
            3'b100: begin
                gidx   = 2'd2;
                g_re_n = REQ2_RE_N;
                g_addr = REQ2_ADDR;
            end
            default: begin
                gidx   = 2'd0;
                g_re_n = REQ0_RE_N;
                g_addr = REQ0_ADDR;
            end
        endcase
    end

    // Round-robin pick: last+1, last+2, then last itself.
    always_comb begin
        cand1    = (last == 2'd2) ? 2'd0 : last + 2'd1;
        cand2    = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
        pick     = last;
        pick_vld = 1'b0;
        if (req[cand1]) begin
            pick     = cand1;
            pick_vld = 1'b1;
        end else if (req[cand2]) begin
            pick     = cand2;
            pick_vld = 1'b1;
        end else if (req[last]) begin
            pick     = last;
            pick_vld = 1'b1;
        end
    end

    // Next state, grant, round-robin pointer and beat counter.
    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        beat_next  = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_next = OWN;
                    grant_next = NREQ'(3'b001 << pick);
                    last_next  = pick;
                    beat_next  = '0;
                end
            end
            OWN: begin
                if (g_re_n) begin
                    state_next = IDLE;
                    grant_next = '0;
                end else if (!SDRAM_WAIT) begin
                    beat_next = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            last     <= 2'd2;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            last     <= last_next;
            beat_cnt <= beat_next;
        end
    end

    // Port mux is combinational so the owner sees SDRAM_WAIT in the same cycle;
    // reset forces the port idle even while the state register still says OWN.
    assign owned      = (state == OWN) && !rst;
    assign SDRAM_RE_N = owned ? g_re_n : 1'b1;
    assign SDRAM_ADDR = owned ? g_addr : '0;
    assign REQ0_WAIT  = (owned && (gidx == 2'd0)) ? SDRAM_WAIT : 1'b1;
    assign REQ1_WAIT  = (owned && (gidx == 2'd1)) ? SDRAM_WAIT : 1'b1;
    assign REQ2_WAIT  = (owned && (gidx == 2'd2)) ? SDRAM_WAIT : 1'b1;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed bench for sdram_rd_arbiter: vector table plus multi-cycle sequences.
// A second instance with a 4-bit counter shares all inputs to check wrap-around.
`ifndef RAM_ADR_W
`define RAM_ADR_W 24
`endif

module tb_sdram_rd_arbiter;

    localparam int unsigned ADR_W = `RAM_ADR_W;
    localparam logic [ADR_W-1:0] A0 = ADR_W'(32'h010);
    localparam logic [ADR_W-1:0] A1 = ADR_W'(32'h100);
    localparam logic [ADR_W-1:0] A2 = ADR_W'(32'h200);

    typedef struct {
        logic             rst;
        logic [2:0]       rn;
        logic             w;
        logic [2:0]       eg;
        logic             esre;
        logic [ADR_W-1:0] ea;
        logic [2:0]       ew;
        logic [15:0]      ec;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       re_n;
    logic             sw;
    logic [2:0]       waits;
    logic             sre_n;
    logic [ADR_W-1:0] saddr;
    logic [2:0]       grant;
    logic [15:0]      cnt;
    logic [2:0]       waits4;
    logic             sre_n4;
    logic [ADR_W-1:0] saddr4;
    logic [2:0]       grant4;
    logic [3:0]       cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_rd_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .REQ0_RE_N(re_n[0]), .REQ0_ADDR(A0), .REQ0_WAIT(waits[0]),
        .REQ1_RE_N(re_n[1]), .REQ1_ADDR(A1), .REQ1_WAIT(waits[1]),
        .REQ2_RE_N(re_n[2]), .REQ2_ADDR(A2), .REQ2_WAIT(waits[2]),
        .SDRAM_RE_N(sre_n), .SDRAM_ADDR(saddr), .SDRAM_WAIT(sw),
        .grant(grant), .beat_cnt(cnt)
    );

    sdram_rd_arbiter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .REQ0_RE_N(re_n[0]), .REQ0_ADDR(A0), .REQ0_WAIT(waits4[0]),
        .REQ1_RE_N(re_n[1]), .REQ1_ADDR(A1), .REQ1_WAIT(waits4[1]),
        .REQ2_RE_N(re_n[2]), .REQ2_ADDR(A2), .REQ2_WAIT(waits4[2]),
        .SDRAM_RE_N(sre_n4), .SDRAM_ADDR(saddr4), .SDRAM_WAIT(sw),
        .grant(grant4), .beat_cnt(cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs on the falling edge, compare just after they settle.
    task automatic step(input string tag, input logic r, input logic [2:0] rn, input logic w,
                        input logic [2:0] eg, input logic esre, input logic [ADR_W-1:0] ea,
                        input logic [2:0] ew, input logic [15:0] ec);
        logic [3:0] ec4;
        @(negedge clk);
        rst  = r;
        re_n = rn;
        sw   = w;
        #1;
        ec4 = ec[3:0];
        chk({tag, " grant"},      32'(grant),  32'(eg));
        chk({tag, " sdram_re_n"}, 32'(sre_n),  32'(esre));
        chk({tag, " sdram_addr"}, 32'(saddr),  32'(ea));
        chk({tag, " req_wait"},   32'(waits),  32'(ew));
        chk({tag, " beat_cnt"},   32'(cnt),    32'(ec));
        chk({tag, " grant_w4"},   32'(grant4), 32'(eg));
        chk({tag, " beat_cnt_w4"}, 32'(cnt4),  32'(ec4));
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] rn, input logic w,
                                input logic [2:0] eg, input logic esre,
                                input logic [ADR_W-1:0] ea, input logic [2:0] ew,
                                input logic [15:0] ec);
        vec_t v;
        v.rst = r; v.rn = rn; v.w = w; v.eg = eg;
        v.esre = esre; v.ea = ea; v.ew = ew; v.ec = ec;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        rst  = 1'b1;
        re_n = 3'b111;
        sw   = 1'b0;

        // Single requester 1, eight accepted beats, then release.
        vecs.push_back(mk(0, 3'b111, 0, 3'b000, 1, '0, 3'b111, 0));
        vecs.push_back(mk(0, 3'b101, 0, 3'b000, 1, '0, 3'b111, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 3'b101, 0, 3'b010, 0, A1, 3'b101, 16'(i)));
        vecs.push_back(mk(0, 3'b111, 0, 3'b010, 1, A1, 3'b101, 8));
        vecs.push_back(mk(0, 3'b111, 0, 3'b000, 1, '0, 3'b111, 8));
        // Reset, then all three contend: 001, 010, 100, 001 with idle gaps.
        vecs.push_back(mk(1, 3'b111, 0, 3'b000, 1, '0, 3'b111, 8));
        vecs.push_back(mk(0, 3'b000, 0, 3'b000, 1, '0, 3'b111, 0));
        vecs.push_back(mk(0, 3'b000, 0, 3'b001, 0, A0, 3'b110, 0));
        vecs.push_back(mk(0, 3'b001, 0, 3'b001, 1, A0, 3'b110, 1));
        vecs.push_back(mk(0, 3'b000, 0, 3'b000, 1, '0, 3'b111, 1));
        vecs.push_back(mk(0, 3'b000, 0, 3'b010, 0, A1, 3'b101, 0));
        vecs.push_back(mk(0, 3'b010, 0, 3'b010, 1, A1, 3'b101, 1));
        vecs.push_back(mk(0, 3'b000, 0, 3'b000, 1, '0, 3'b111, 1));
        vecs.push_back(mk(0, 3'b000, 0, 3'b100, 0, A2, 3'b011, 0));
        vecs.push_back(mk(0, 3'b100, 0, 3'b100, 1, A2, 3'b011, 1));
        vecs.push_back(mk(0, 3'b000, 0, 3'b000, 1, '0, 3'b111, 1));
        vecs.push_back(mk(0, 3'b111, 0, 3'b001, 1, A0, 3'b110, 0));
        vecs.push_back(mk(0, 3'b111, 0, 3'b000, 1, '0, 3'b111, 0));

        repeat (2) @(posedge clk);

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].rn, vecs[i].w,
                 vecs[i].eg, vecs[i].esre, vecs[i].ea, vecs[i].ew, vecs[i].ec);

        // Stall: owner 0 frozen for five cycles while requester 2 toggles.
        step("st_req", 0, 3'b110, 0, 3'b000, 1, '0, 3'b111, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("st_beat%0d", i), 0, 3'b110, 0, 3'b001, 0, A0, 3'b110, 16'(i));
        for (int i = 0; i < 5; i++)
            step($sformatf("st_stall%0d", i), 0, (i % 2) ? 3'b010 : 3'b110, 1,
                 3'b001, 0, A0, 3'b111, 3);
        for (int i = 0; i < 2; i++)
            step($sformatf("st_resume%0d", i), 0, 3'b110, 0, 3'b001, 0, A0, 3'b110, 16'(3 + i));
        step("st_rel", 0, 3'b111, 0, 3'b001, 1, A0, 3'b110, 5);
        step("st_idle", 0, 3'b111, 0, 3'b000, 1, '0, 3'b111, 5);

        // Lock: owner 2 holds 20 cycles with 0 and 1 pending.
        step("lk_req", 0, 3'b011, 0, 3'b000, 1, '0, 3'b111, 5);
        for (int i = 0; i < 20; i++)
            step($sformatf("lk_hold%0d", i), 0, 3'b000, 0, 3'b100, 0, A2, 3'b011, 16'(i));
        step("lk_rel", 0, 3'b100, 0, 3'b100, 1, A2, 3'b011, 20);
        step("lk_turn", 0, 3'b000, 0, 3'b000, 1, '0, 3'b111, 20);
        step("lk_next", 0, 3'b000, 0, 3'b001, 0, A0, 3'b110, 0);

        // Reset mid-burst of owner 1, then requester 0 wins first.
        step("rs_rel0", 0, 3'b111, 0, 3'b001, 1, A0, 3'b110, 1);
        step("rs_idle", 0, 3'b111, 0, 3'b000, 1, '0, 3'b111, 1);
        step("rs_req1", 0, 3'b101, 0, 3'b000, 1, '0, 3'b111, 1);
        for (int i = 0; i < 3; i++)
            step($sformatf("rs_beat%0d", i), 0, 3'b101, 0, 3'b010, 0, A1, 3'b101, 16'(i));
        step("rs_in", 1, 3'b101, 0, 3'b010, 1, '0, 3'b111, 3);
        step("rs_after", 0, 3'b000, 0, 3'b000, 1, '0, 3'b111, 0);
        step("rs_first", 0, 3'b000, 0, 3'b001, 0, A0, 3'b110, 0);

        // Wrap: 18 beats, the 4-bit instance must read 2.
        step("wr_rel0", 0, 3'b111, 0, 3'b001, 1, A0, 3'b110, 1);
        step("wr_req", 0, 3'b110, 0, 3'b000, 1, '0, 3'b111, 1);
        for (int i = 0; i < 18; i++)
            step($sformatf("wr_beat%0d", i), 0, 3'b110, 0, 3'b001, 0, A0, 3'b110, 16'(i));
        step("wr_rel", 0, 3'b111, 0, 3'b001, 1, A0, 3'b110, 18);
        step("wr_idle", 0, 3'b111, 0, 3'b000, 1, '0, 3'b111, 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_rd_arbiter.md
SDRAM_RD_ARBITER -- requirements
Module: sdram_rd_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the per-grant beat counter.
REQ-002 The block SHALL take the address width from macro `RAM_ADR_W.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- REQ0_RE_N  input  1  requester 0 read enable, active-low; low = requesting/holding.
- REQ0_ADDR  input  `RAM_ADR_W  requester 0 read address.
- REQ0_WAIT  output  1  requester 0 stall; 0 = word accepted this cycle.
- REQ1_RE_N, REQ1_ADDR, REQ1_WAIT  same as requester 0, for requester 1.
- REQ2_RE_N, REQ2_ADDR, REQ2_WAIT  same as requester 0, for requester 2.
- SDRAM_RE_N  output  1  shared port read enable, active-low.
- SDRAM_ADDR  output  `RAM_ADR_W  shared port address.
- SDRAM_WAIT  input  1  shared port stall.
- grant  output  3  one-hot registered grant; 0 = no owner.
- beat_cnt  output  CNT_W  words accepted in the current/last grant.

Function
REQ-004 The state machine SHALL have two states: IDLE (no owner) and OWN (exactly one grant bit set).
REQ-005 In IDLE with at least one REQi_RE_N low, the block SHALL select one requester and enter OWN at the next edge, setting grant to that one-hot value.
- Latency: request sampled at cycle t; grant and SDRAM_RE_N low at cycle t+1.
REQ-006 Selection SHALL be round-robin from register last (0..2): priority order (last+1)%3, (last+2)%3, last.
REQ-007 The block SHALL load last with the selected index when entering OWN.
REQ-008 In IDLE with no requests, the block SHALL stay in IDLE with grant = 0.
REQ-009 In OWN, the block SHALL combinationally drive SDRAM_RE_N = REQg_RE_N, SDRAM_ADDR = REQg_ADDR, and REQg_WAIT = SDRAM_WAIT, where g is the granted index.
REQ-010 In IDLE, the block SHALL drive SDRAM_RE_N = 1 and SDRAM_ADDR = 0.
REQ-011 Every non-granted REQi_WAIT SHALL be 1 in all states, so that non-owners never advance.
REQ-012 The grant SHALL be held (burst lock) while REQg_RE_N = 0; no preemption.
REQ-013 In OWN, when REQg_RE_N = 1 is sampled, the block SHALL return to IDLE at the next edge with grant = 0.
- SDRAM_RE_N rises in the same cycle via REQ-009.
- One IDLE turnaround cycle always separates consecutive grants, including when other requests are pending at release.
REQ-014 beat_cnt SHALL clear to 0 on entry to OWN.
REQ-015 beat_cnt SHALL increment by 1 on each OWN cycle with REQg_RE_N = 0 and SDRAM_WAIT = 0.
REQ-016 beat_cnt SHALL hold its value in IDLE and SHALL wrap modulo 2^CNT_W.
REQ-017 While SDRAM_WAIT = 1, the block SHALL hold grant and beat_cnt and keep the owner's REQg_WAIT = 1.
REQ-018 A requester that deasserts RE_N while not granted SHALL have no effect on state, last or beat_cnt.
REQ-019 Simultaneous release and new requests SHALL follow REQ-013 first, then REQ-005/REQ-006 in the following IDLE cycle.

Reset
REQ-020 While rst = 1 at a rising edge, the block SHALL set state = IDLE, grant = 0, last = 2 (requester 0 first priority), and beat_cnt = 0.
REQ-021 While in reset, outputs SHALL be SDRAM_RE_N = 1, SDRAM_ADDR = 0, and all REQi_WAIT = 1.
REQ-022 Reset asserted mid-burst SHALL release the port at the next edge regardless of REQg_RE_N, with no further beats counted.
REQ-023 After reset deasserts, arbitration SHALL resume per REQ-005.

Verification
REQ-024 Single requester: REQ1_RE_N low, address 0x100, SDRAM_WAIT = 0 for 8 cycles, then high -> grant = 3'b010 one cycle after the request; SDRAM_ADDR = 0x100; REQ0_WAIT = REQ2_WAIT = 1; beat_cnt = 8; grant = 0 the cycle after release.
REQ-025 Contention after reset: all three RE_N low together -> grant order 001, 010, 100, 001, each separated by one cycle of grant = 0.
REQ-026 Stall: owner 0, SDRAM_WAIT = 1 for 5 cycles mid-burst -> REQ0_WAIT = 1, beat_cnt frozen, grant unchanged; counting resumes when SDRAM_WAIT = 0.
REQ-027 Lock: owner 2 holds RE_N low for 20 cycles while requesters 0 and 1 are pending -> grant stays 100, and REQ0_WAIT and REQ1_WAIT are 1 throughout.
REQ-028 Reset mid-burst: rst = 1 for 1 cycle during owner-1 burst -> next cycle grant = 0, SDRAM_RE_N = 1, beat_cnt = 0; with all three requesting afterwards, requester 0 is granted first.
REQ-029 Wrap: CNT_W = 4, 18 accepted beats -> beat_cnt = 2.
